// File: rtl/maze_bfs_solver_if.sv
// Load/result bundle of maze_bfs_solver: serial maze bits in, busy and path coordinates out.
interface maze_bfs_solver_if #(
    parameter int COORD_W = 5
);
    logic               in_valid;
    logic               maze;
    logic               busy;
    logic               out_valid;
    logic               maze_not_valid;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;

    modport master (
        output in_valid,
        output maze,
        input  busy,
        input  out_valid,
        input  maze_not_valid,
        input  out_x,
        input  out_y
    );

    modport slave (
        input  in_valid,
        input  maze,
        output busy,
        output out_valid,
        output maze_not_valid,
        output out_x,
        output out_y
    );
endinterface

// File: rtl/maze_bfs_solver.sv
// BFS shortest-path solver for a serially loaded MAZE_DIM x MAZE_DIM binary maze.
// Define MAZE_FWD_PATH_EN to root the search at the goal so the path streams start -> goal.
module maze_bfs_solver #(
    parameter int MAZE_DIM    = 17,
    parameter int QUEUE_DEPTH = 32,
    parameter int COORD_W     = 5
) (
    input logic              clk,
    input logic              rst_n,
    maze_bfs_solver_if.slave bus
);
    localparam int CELLS  = MAZE_DIM * MAZE_DIM;
    localparam int CELL_W = $clog2(CELLS);
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int OCC_W  = PTR_W + 3;

    localparam logic [COORD_W-1:0] LAST      = COORD_W'(MAZE_DIM - 1);
    localparam logic [CELL_W-1:0]  START_IDX = '0;
    localparam logic [CELL_W-1:0]  GOAL_IDX  = CELL_W'(CELLS - 1);
    localparam logic [OCC_W-1:0]   OCC_MAX   = OCC_W'(QUEUE_DEPTH);

`ifdef MAZE_FWD_PATH_EN
    localparam logic [COORD_W-1:0] ROOT_C = LAST;
    localparam logic [COORD_W-1:0] TGT_C  = '0;
`else
    localparam logic [COORD_W-1:0] ROOT_C = '0;
    localparam logic [COORD_W-1:0] TGT_C  = LAST;
`endif

    localparam logic [2:0] S_LOAD   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_SEARCH = 3'd2;
    localparam logic [2:0] S_TRACE  = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Direction in which a cell was discovered from its parent.
    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    logic [2:0]           state;
    logic [CELL_W-1:0]    cnt;
    logic [CELLS-1:0]     maze_bits;
    logic [CELLS-1:0]     visited;
    logic [1:0]           parent [CELLS];
    logic [2*COORD_W-1:0] queue  [QUEUE_DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [OCC_W-1:0]     occ;

    logic                 busy;
    logic                 out_valid;
    logic                 maze_not_valid;
    logic [COORD_W-1:0]   out_x;
    logic [COORD_W-1:0]   out_y;

    logic [COORD_W-1:0]   hx;
    logic [COORD_W-1:0]   hy;
    logic                 head_hit;
    logic [COORD_W-1:0]   nx   [4];
    logic [COORD_W-1:0]   ny   [4];
    logic [CELL_W-1:0]    nidx [4];
    logic [PTR_W-1:0]     slot [4];
    logic [3:0]           inb;
    logic [3:0]           push;
    logic [2:0]           npush;
    logic [OCC_W-1:0]     occ_next;
    logic [1:0]           trace_dir;

    function automatic logic [CELL_W-1:0] cell_idx(input logic [COORD_W-1:0] y,
                                                   input logic [COORD_W-1:0] x);
        return CELL_W'(int'(y) * MAZE_DIM + int'(x));
    endfunction

    assign {hy, hx}  = queue[head];
    assign head_hit  = (hx == TGT_C) && (hy == TGT_C);
    assign trace_dir = parent[cell_idx(out_y, out_x)];

    // Neighbour expansion of the queue head; pushes pack contiguously after tail.
    always_comb begin
        nx[0] = hx - COORD_W'(1);  ny[0] = hy;                inb[0] = (hx != '0);
        nx[1] = hx;                ny[1] = hy - COORD_W'(1);  inb[1] = (hy != '0);
        nx[2] = hx + COORD_W'(1);  ny[2] = hy;                inb[2] = (hx != LAST);
        nx[3] = hx;                ny[3] = hy + COORD_W'(1);  inb[3] = (hy != LAST);
        push  = '0;
        npush = '0;
        for (int d = 0; d < 4; d++) begin
            nidx[d] = inb[d] ? cell_idx(ny[d], nx[d]) : '0;
            push[d] = inb[d] && !maze_bits[nidx[d]] && !visited[nidx[d]];
            slot[d] = tail + PTR_W'(npush);
            npush   = npush + 3'(push[d]);
        end
        occ_next = occ - OCC_W'(1) + OCC_W'(npush);
    end

    // Queue storage holds data only; head/tail/occ decide what is live.
    always_ff @(posedge clk) begin
        if (state == S_CHECK) begin
            queue[tail] <= {ROOT_C, ROOT_C};
        end else if (state == S_SEARCH && !head_hit) begin
            for (int d = 0; d < 4; d++) begin
                if (push[d]) queue[slot[d]] <= {ny[d], nx[d]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_LOAD;
            cnt            <= '0;
            maze_bits      <= '0;
            visited        <= '0;
            head           <= '0;
            tail           <= '0;
            occ            <= '0;
            busy           <= 1'b0;
            out_valid      <= 1'b0;
            maze_not_valid <= 1'b0;
            out_x          <= '0;
            out_y          <= '0;
            for (int i = 0; i < CELLS; i++) parent[i] <= DIR_LEFT;
        end else begin
            case (state)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        busy           <= 1'b1;
                        maze_bits[cnt] <= bus.maze;
                        if (cnt == GOAL_IDX) begin
                            cnt   <= '0;
                            state <= S_CHECK;
                        end else begin
                            cnt <= cnt + CELL_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (maze_bits[START_IDX] || maze_bits[GOAL_IDX]) begin
                        state          <= S_FAIL;
                        out_valid      <= 1'b1;
                        maze_not_valid <= 1'b1;
                    end else begin
                        visited[cell_idx(ROOT_C, ROOT_C)] <= 1'b1;
                        tail  <= tail + PTR_W'(1);
                        occ   <= OCC_W'(1);
                        state <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (head_hit) begin
                        state     <= S_TRACE;
                        out_valid <= 1'b1;
                        out_x     <= hx;
                        out_y     <= hy;
                    end else if (occ_next > OCC_MAX || occ_next == '0) begin
                        // Overflow or exhausted frontier: the target cannot be reported.
                        state          <= S_FAIL;
                        out_valid      <= 1'b1;
                        maze_not_valid <= 1'b1;
                    end else begin
                        head <= head + PTR_W'(1);
                        tail <= tail + PTR_W'(npush);
                        occ  <= occ_next;
                        for (int d = 0; d < 4; d++) begin
                            if (push[d]) begin
                                visited[nidx[d]] <= 1'b1;
                                parent[nidx[d]]  <= 2'(d);
                            end
                        end
                    end
                end
                S_TRACE: begin
                    if (out_x == ROOT_C && out_y == ROOT_C) begin
                        out_valid <= 1'b0;
                        out_x     <= '0;
                        out_y     <= '0;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        // Step back against the discovery direction toward the root.
                        case (trace_dir)
                            DIR_LEFT:  out_x <= out_x + COORD_W'(1);
                            DIR_UP:    out_y <= out_y + COORD_W'(1);
                            DIR_RIGHT: out_x <= out_x - COORD_W'(1);
                            default:   out_y <= out_y - COORD_W'(1);
                        endcase
                    end
                end
                S_FAIL: begin
                    out_valid      <= 1'b0;
                    maze_not_valid <= 1'b0;
                    busy           <= 1'b0;
                    state          <= S_DONE;
                end
                S_DONE: begin
                    visited <= '0;
                    cnt     <= '0;
                    head    <= '0;
                    tail    <= '0;
                    occ     <= '0;
                    for (int i = 0; i < CELLS; i++) parent[i] <= DIR_LEFT;
                    state   <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign bus.busy           = busy;
    assign bus.out_valid      = out_valid;
    assign bus.maze_not_valid = maze_not_valid;
    assign bus.out_x          = out_x;
    assign bus.out_y          = out_y;

endmodule

// File: tb/tb_maze_bfs_solver.sv
// Scoreboard bench for maze_bfs_solver: two 5x5 instances (queue depth 32 and 2) share one stimulus stream.
module tb_maze_bfs_solver;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    maze_bfs_solver_if #(.COORD_W(5)) ifa ();
    maze_bfs_solver_if #(.COORD_W(5)) ifb ();

    maze_bfs_solver #(.MAZE_DIM(N), .QUEUE_DEPTH(32), .COORD_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    maze_bfs_solver #(.MAZE_DIM(N), .QUEUE_DEPTH(2), .COORD_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [10:0] exp_a[$];
    logic [10:0] exp_b[$];
    logic [10:0] ea, eb;
    int seen_a = 0, run_a = 0, last_run_a = 0;
    int run_b = 0, last_run_b = 0;

    // Entry layout {maze_not_valid, y, x}
    function automatic logic [10:0] ent(input logic nv, input int x, input int y);
        return {nv, 5'(y), 5'(x)};
    endfunction

    function automatic logic [24:0] l_maze();
        logic [24:0] m;
        for (int i = 0; i < 25; i++) m[i] = !((i % N) == 0 || (i / N) == 4);
        return m;
    endfunction

    // Scoreboard: every out_valid cycle pops one expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifa.out_valid) begin
                n_cmp++;
                if (exp_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_a_unexpected got nv=%0d x=%0d y=%0d want none",
                             ifa.maze_not_valid, ifa.out_x, ifa.out_y);
                end else begin
                    ea = exp_a.pop_front();
                    if ({ifa.maze_not_valid, ifa.out_y, ifa.out_x} !== ea) begin
                        n_fail++;
                        $display("FAIL out_a got nv=%0d x=%0d y=%0d want nv=%0d x=%0d y=%0d",
                                 ifa.maze_not_valid, ifa.out_x, ifa.out_y, ea[10], ea[4:0], ea[9:5]);
                    end
                end
                seen_a++;
                run_a++;
            end else if (run_a != 0) begin
                last_run_a = run_a;
                run_a = 0;
            end
            if (ifb.out_valid) begin
                n_cmp++;
                if (exp_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_b_unexpected got nv=%0d x=%0d y=%0d want none",
                             ifb.maze_not_valid, ifb.out_x, ifb.out_y);
                end else begin
                    eb = exp_b.pop_front();
                    if ({ifb.maze_not_valid, ifb.out_y, ifb.out_x} !== eb) begin
                        n_fail++;
                        $display("FAIL out_b got nv=%0d x=%0d y=%0d want nv=%0d x=%0d y=%0d",
                                 ifb.maze_not_valid, ifb.out_x, ifb.out_y, eb[10], eb[4:0], eb[9:5]);
                    end
                end
                run_b++;
            end else if (run_b != 0) begin
                last_run_b = run_b;
                run_b = 0;
            end
        end
    end

    task automatic push_l_path();
        for (int k = 4; k >= 0; k--) begin exp_a.push_back(ent(1'b0, k, 4)); exp_b.push_back(ent(1'b0, k, 4)); end
        for (int k = 3; k >= 0; k--) begin exp_a.push_back(ent(1'b0, 0, k)); exp_b.push_back(ent(1'b0, 0, k)); end
    endtask

    task automatic push_fail();
        exp_a.push_back(ent(1'b1, 0, 0));
        exp_b.push_back(ent(1'b1, 0, 0));
    endtask

    task automatic drive_maze(input logic [24:0] m, input int gap);
        for (int i = 0; i < 25; i++) begin
            if (gap != 0 && (i % gap) == gap - 1) begin
                @(negedge clk);
                ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
            end
            @(negedge clk);
            ifa.in_valid = 1'b1; ifa.maze = m[i];
            ifb.in_valid = 1'b1; ifb.maze = m[i];
        end
        @(negedge clk);
        ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (!ifa.busy && !ifb.busy && exp_a.size() == 0 && exp_b.size() == 0) break;
        end
        n_cmp++;
        if (k == budget) begin
            n_fail++;
            $display("FAIL %s_idle_timeout got pending a=%0d b=%0d want 0", name, exp_a.size(), exp_b.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        ifa.in_valid = 1'b0; ifa.maze = 1'b0;
        ifb.in_valid = 1'b0; ifb.maze = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ifa.busy, ifa.out_valid, ifa.maze_not_valid, ifa.out_x, ifa.out_y} !== 13'd0) begin
            n_fail++; $display("FAIL reset_a got busy=%0d ov=%0d x=%0d y=%0d want all 0", ifa.busy, ifa.out_valid, ifa.out_x, ifa.out_y);
        end
        n_cmp++;
        if ({ifb.busy, ifb.out_valid, ifb.maze_not_valid, ifb.out_x, ifb.out_y} !== 13'd0) begin
            n_fail++; $display("FAIL reset_b got busy=%0d ov=%0d x=%0d y=%0d want all 0", ifb.busy, ifb.out_valid, ifb.out_x, ifb.out_y);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ifa.busy !== 1'b0 || ifa.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset got busy=%0d ov=%0d want 0 0", ifa.busy, ifa.out_valid);
        end
    endtask

    task automatic test_l_corridor();
        push_l_path();
        drive_maze(l_maze(), 7);
        #1;
        n_cmp++;
        if (ifa.busy !== 1'b1) begin n_fail++; $display("FAIL l_busy got %0d want 1", ifa.busy); end
        wait_idle("l_corridor", 200);
        n_cmp++;
        if (last_run_a !== 9) begin n_fail++; $display("FAIL l_run_a got %0d want 9", last_run_a); end
        n_cmp++;
        if (last_run_b !== 9) begin n_fail++; $display("FAIL l_run_b got %0d want 9", last_run_b); end
    endtask

    task automatic test_start_wall();
        logic [24:0] m;
        m = '0;
        m[0] = 1'b1;
        push_fail();
        drive_maze(m, 0);
        #1;
        n_cmp++;
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL sw_early got ov=%0d want 0", ifa.out_valid); end
        @(negedge clk); #1;
        n_cmp++;
        if (ifa.out_valid !== 1'b1 || ifa.maze_not_valid !== 1'b1) begin
            n_fail++; $display("FAIL sw_pulse got ov=%0d nv=%0d want 1 1", ifa.out_valid, ifa.maze_not_valid);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (ifa.out_valid !== 1'b0 || ifa.maze_not_valid !== 1'b0) begin
            n_fail++; $display("FAIL sw_single got ov=%0d nv=%0d want 0 0", ifa.out_valid, ifa.maze_not_valid);
        end
        wait_idle("start_wall", 50);
        n_cmp++;
        if (last_run_a !== 1) begin n_fail++; $display("FAIL sw_run got %0d want 1", last_run_a); end
    endtask

    task automatic test_unreachable();
        logic [24:0] m;
        m = '0;
        for (int c = 0; c < N; c++) m[2*N + c] = 1'b1;
        push_fail();
        drive_maze(m, 5);
        wait_idle("unreachable", 300);
        n_cmp++;
        if (last_run_a !== 1) begin n_fail++; $display("FAIL unreach_run got %0d want 1", last_run_a); end
    endtask

    task automatic test_overflow();
        for (int k = 4; k >= 0; k--) exp_a.push_back(ent(1'b0, 4, k));
        for (int k = 3; k >= 0; k--) exp_a.push_back(ent(1'b0, k, 0));
        exp_b.push_back(ent(1'b1, 0, 0));
        drive_maze('0, 0);
        wait_idle("overflow", 300);
        n_cmp++;
        if (last_run_a !== 9) begin n_fail++; $display("FAIL open_run_a got %0d want 9", last_run_a); end
        n_cmp++;
        if (last_run_b !== 1) begin n_fail++; $display("FAIL ovf_run_b got %0d want 1", last_run_b); end
    endtask

    task automatic test_back_to_back();
        logic [24:0] m;
        int k;
        push_l_path();
        drive_maze(l_maze(), 0);
        repeat (3) begin
            @(negedge clk);
            ifa.in_valid = 1'b1; ifa.maze = 1'b1;
            ifb.in_valid = 1'b1; ifb.maze = 1'b1;
        end
        @(negedge clk);
        ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (!ifa.busy) break;
        end
        n_cmp++;
        if (k == 200) begin n_fail++; $display("FAIL b2b_done_timeout got busy=1 want 0"); end
        n_cmp++;
        if (last_run_a !== 9) begin n_fail++; $display("FAIL b2b_run got %0d want 9", last_run_a); end
        m = l_maze();
        m[0] = 1'b1;
        push_fail();
        drive_maze(m, 0);
        wait_idle("back_to_back", 100);
        n_cmp++;
        if (last_run_a !== 1) begin n_fail++; $display("FAIL b2b_fail_run got %0d want 1", last_run_a); end
    endtask

    task automatic test_reset_mid_trace();
        int s0, k;
        s0 = seen_a;
        push_l_path();
        drive_maze(l_maze(), 0);
        for (k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (seen_a - s0 >= 3) break;
        end
        n_cmp++;
        if (k == 300) begin n_fail++; $display("FAIL mid_trace_timeout got %0d coords want 3", seen_a - s0); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ifa.busy, ifa.out_valid, ifa.maze_not_valid, ifa.out_x, ifa.out_y} !== 13'd0) begin
            n_fail++; $display("FAIL async_reset_a got busy=%0d ov=%0d x=%0d y=%0d want all 0", ifa.busy, ifa.out_valid, ifa.out_x, ifa.out_y);
        end
        n_cmp++;
        if ({ifb.busy, ifb.out_valid, ifb.out_x, ifb.out_y} !== 12'd0) begin
            n_fail++; $display("FAIL async_reset_b got busy=%0d ov=%0d x=%0d y=%0d want all 0", ifb.busy, ifb.out_valid, ifb.out_x, ifb.out_y);
        end
        exp_a.delete();
        exp_b.delete();
        run_a = 0;
        run_b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_l_path();
        drive_maze(l_maze(), 4);
        wait_idle("after_reset", 200);
        n_cmp++;
        if (last_run_a !== 9) begin n_fail++; $display("FAIL post_reset_run got %0d want 9", last_run_a); end
    endtask

    initial begin
        test_reset();
        test_l_corridor();
        test_start_wall();
        test_unreachable();
        test_overflow();
        test_back_to_back();
        test_reset_mid_trace();
        n_cmp++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_fail++; $display("FAIL leftover got a=%0d b=%0d want 0 0", exp_a.size(), exp_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
